// File: rtl/mux_4x1_rr.sv
// Four-lane round-robin merging multiplexer: per-lane FIFOs drained by a
// rotating-priority arbiter into a single registered output stream.

module mux_4x1_rr_lane #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  pause,
  output logic                  overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  full;
  logic                  push;
  logic                  drop;

  // Full is taken from the registered count, so a pop on this edge never
  // makes room for a write on the same edge.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no latch can be inferred.
    full       = (count == CW'(DEPTH));
    push       = valid && !full;
    drop       = valid && full;
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pause    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count_next;
      pause    <= (count_next >= CW'(AF_LEVEL));
      overflow <= drop;
    end
  end

  // NOTE: the storage array is deliberately not reset; a zero count already
  // marks every entry as stale, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule

module mux_4x1_rr #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  valid_0,
  input  logic                  valid_1,
  input  logic                  valid_2,
  input  logic                  valid_3,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            class_out,  // "class" is a reserved word
  output logic                  valid_out,
  output logic                  pause_0,
  output logic                  pause_1,
  output logic                  pause_2,
  output logic                  pause_3,
  output logic                  overflow_0,
  output logic                  overflow_1,
  output logic                  overflow_2,
  output logic                  overflow_3
);

  logic [DATA_WIDTH-1:0] lane_data [4];
  logic [DATA_WIDTH-1:0] head      [4];
  logic [3:0]            lane_valid;
  logic [3:0]            empty;
  logic [3:0]            pop;
  logic [3:0]            pause;
  logic [3:0]            overflow;
  logic [1:0]            last_grant;
  logic [1:0]            winner;
  logic                  found;
  logic                  stage_free;

  assign lane_data[0] = data_in0;
  assign lane_data[1] = data_in1;
  assign lane_data[2] = data_in2;
  assign lane_data[3] = data_in3;
  assign lane_valid   = {valid_3, valid_2, valid_1, valid_0};

  for (genvar n = 0; n < 4; n++) begin : g_lane
    mux_4x1_rr_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AF_LEVEL   (AF_LEVEL)
    ) u_lane (
      .clk      (clk),
      .reset_L  (reset_L),
      .data_in  (lane_data[n]),
      .valid    (lane_valid[n]),
      .pop      (pop[n]),
      .head     (head[n]),
      .empty    (empty[n]),
      .pause    (pause[n]),
      .overflow (overflow[n])
    );
  end

  assign {pause_3, pause_2, pause_1, pause_0}             = pause;
  assign {overflow_3, overflow_2, overflow_1, overflow_0} = overflow;

  // Scan starts one past the last grant; the 2-bit sum wraps, and the
  // fourth step revisits the last winner itself.
  always_comb begin
    stage_free = !valid_out || out_ready;
    found      = 1'b0;
    winner     = last_grant;
    for (int i = 1; i <= 4; i++) begin
      if (!found && !empty[last_grant + 2'(i)]) begin
        found  = 1'b1;
        winner = last_grant + 2'(i);
      end
    end
    pop = '0;
    if (stage_free && found) pop[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out   <= '0;
      class_out  <= '0;
      valid_out  <= 1'b0;
      last_grant <= 2'd3;
    end else if (stage_free) begin
      if (found) begin
        data_out   <= head[winner];
        class_out  <= winner;
        valid_out  <= 1'b1;
        last_grant <= winner;
      end else begin
        valid_out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_4x1_rr.sv
// Self-checking bench for mux_4x1_rr: directed scenarios plus random traffic,
// all compared against a queue-based behavioural model.

module tb_mux_4x1_rr;

  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic [DW-1:0] din [4];
  logic [3:0]    vin = '0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] data_out;
  logic [1:0]    class_out;
  logic          valid_out;
  logic          pause_0, pause_1, pause_2, pause_3;
  logic          overflow_0, overflow_1, overflow_2, overflow_3;
  logic [3:0]    pause_v;
  logic [3:0]    overflow_v;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [DW-1:0] q [4][$];
  int            m_grant;
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_class;
  bit            m_pause [4];
  bit            m_ovf [4];

  always #5 clk = ~clk;

  assign pause_v    = {pause_3, pause_2, pause_1, pause_0};
  assign overflow_v = {overflow_3, overflow_2, overflow_1, overflow_0};

  mux_4x1_rr #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in0   (din[0]),
    .data_in1   (din[1]),
    .data_in2   (din[2]),
    .data_in3   (din[3]),
    .valid_0    (vin[0]),
    .valid_1    (vin[1]),
    .valid_2    (vin[2]),
    .valid_3    (vin[3]),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .class_out  (class_out),
    .valid_out  (valid_out),
    .pause_0    (pause_0),
    .pause_1    (pause_1),
    .pause_2    (pause_2),
    .pause_3    (pause_3),
    .overflow_0 (overflow_0),
    .overflow_1 (overflow_1),
    .overflow_2 (overflow_2),
    .overflow_3 (overflow_3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      q[n].delete();
      m_pause[n] = 1'b0;
      m_ovf[n]   = 1'b0;
    end
    m_grant = 3;
    m_valid = 1'b0;
    m_data  = '0;
    m_class = 0;
  endtask

  // One rising edge of the specified behaviour, using pre-edge occupancies.
  task automatic model_edge();
    int sz [4];
    int win;
    bit free;
    if (!reset_L) begin
      model_reset();
      return;
    end
    for (int n = 0; n < 4; n++) sz[n] = q[n].size();
    free = !m_valid || out_ready;
    win  = -1;
    if (free) begin
      for (int k = 1; k <= 4; k++) begin
        int l = (m_grant + k) % 4;
        if (win < 0 && sz[l] > 0) win = l;
      end
      if (win >= 0) begin
        m_data  = q[win].pop_front();
        m_class = win;
        m_valid = 1'b1;
        m_grant = win;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int n = 0; n < 4; n++) begin
      m_ovf[n] = 1'b0;
      if (vin[n]) begin
        if (sz[n] < DEPTH) q[n].push_back(din[n]);
        else               m_ovf[n] = 1'b1;
      end
      m_pause[n] = (q[n].size() >= AF);
    end
  endtask

  task automatic compare_model();
    check("valid_out", valid_out, m_valid);
    if (m_valid) begin
      check("data_out", data_out, m_data);
      check("class", class_out, m_class);
    end
    for (int n = 0; n < 4; n++) begin
      check($sformatf("pause_%0d", n), pause_v[n], m_pause[n]);
      check($sformatf("overflow_%0d", n), overflow_v[n], m_ovf[n]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic drive(input logic [3:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    vin    = v;
    din[0] = d0;
    din[1] = d1;
    din[2] = d2;
    din[3] = d3;
  endtask

  task automatic idle();
    drive(4'b0000, '0, '0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, valid_out, 1'b0);
    check({tag, "_data"}, data_out, '0);
    check({tag, "_class"}, class_out, '0);
    check({tag, "_pause"}, pause_v, 4'b0000);
    check({tag, "_overflow"}, overflow_v, 4'b0000);
  endtask

  initial begin
    model_reset();

    // Reset held with random inputs
    reset_L = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(4'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      out_ready = 1'($urandom);
      @(posedge clk);
      model_edge();
      #1;
      check_all_zero("rst");
    end
    reset_L   = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (3) step();

    // Single stream, one lane per cycle
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001 << i, 12'd1, 12'd2, 12'd3, 12'd4);
      step();
      if (i > 0) begin
        check("ss_data", data_out, i);
        check("ss_class", class_out, i - 1);
      end
    end
    idle();
    step();
    check("ss_data", data_out, 4);
    check("ss_class", class_out, 3);

    // Round robin across four lanes written on the same edge
    drive(4'b1111, 12'd10, 12'd11, 12'd12, 12'd13);
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_class", class_out, k);
      check("rr_data", data_out, 10 + k);
    end
    drive(4'b0100, '0, '0, 12'd20, '0);
    step();
    idle();
    step();
    check("rr_lane2_class", class_out, 2);
    check("rr_lane2_data", data_out, 20);
    step();

    // Backpressure on lane 1
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'b0010, '0, DW'(30 + i), '0, '0);
      step();
    end
    idle();
    repeat (2) begin
      step();
      check("bp_hold_data", data_out, 30);
      check("bp_hold_valid", valid_out, 1'b1);
      check("bp_pause_1", pause_1, 1'b1);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check("bp_drain", data_out, 30 + i);
    end
    step();

    // Overflow on lane 3 with the output stage stalled
    out_ready = 1'b0;
    drive(4'b0001, 12'd39, '0, '0, '0);
    step();
    idle();
    step();
    for (int i = 0; i < 6; i++) begin
      drive(4'b1000, '0, '0, '0, DW'(40 + i));
      step();
      check("ovf_3", overflow_3, (i >= 4));
    end
    idle();
    step();
    check("ovf_3_clear", overflow_3, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ovf_drain", data_out, 40 + i);
    end
    step();
    check("ovf_drain_end", valid_out, 1'b0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      drive(4'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Asynchronous reset while lanes hold data
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(4'b1111, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      step();
    end
    #2;
    reset_L = 1'b0;
    #1;
    check_all_zero("mid_rst");
    model_reset();
    repeat (2) step();
    reset_L   = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (5) begin
      step();
      check("no_stale", valid_out, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
